// File: rtl/music_ctrl_regs.sv
// Front-panel control registers: debounces seven push-buttons and turns presses
// and end-of-song pulses into persistent play/music/volume/speed/order state.
module music_ctrl_regs #(
   parameter int unsigned DEBOUNCE_CYC = 1_000_000,
   parameter int unsigned CNT_W        = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] key_n,
   input  logic       song_end,
   output logic       order_reg,
   output logic [1:0] music_reg,
   output logic [2:0] volume_reg,
   output logic [1:0] speed_reg,
   output logic       play_reg,
   output logic [6:0] key_pulse,
   output logic       restart
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYC - 1);

   logic [6:0]       sync1_q, sync2_q;
   logic [6:0]       stable_q, stable_d, stable_dly_q;
   logic [CNT_W-1:0] cnt_q [7];
   logic [CNT_W-1:0] cnt_d [7];
   logic [6:0]       key_pulse_q, key_pulse_d;

   logic       order_q, order_d;
   logic [1:0] music_q, music_d;
   logic [2:0] volume_q, volume_d;
   logic [1:0] speed_q, speed_d;
   logic       play_q, play_d;
   logic       restart_pend_q, restart_pend_d;
   logic       restart_q;
   logic       song_acc;

   function automatic logic [1:0] nextSong(input logic [1:0] m);
      return (m == 2'd3) ? 2'd1 : m + 2'd1;
   endfunction

   function automatic logic [1:0] prevSong(input logic [1:0] m);
      logic [1:0] r;
      case (m)
         2'd0:    r = 2'd3;
         2'd1:    r = 2'd3;
         2'd2:    r = 2'd1;
         default: r = 2'd2;
      endcase
      return r;
   endfunction

   // A differing synced level must persist for DEBOUNCE_CYC cycles to be accepted.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 7; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      key_pulse_d = stable_dly_q & ~stable_q;
   end

   always_comb begin
      order_d        = order_q;
      music_d        = music_q;
      volume_d       = volume_q;
      speed_d        = speed_q;
      play_d         = play_q;
      restart_pend_d = 1'b0;
      song_acc       = song_end && play_q && (music_q != 2'd0);

      // Music source priority: song_end, next, prev, then play-from-idle.
      if (song_acc) begin
         if (!order_q) begin
            music_d = nextSong(music_q);
         end else begin
            restart_pend_d = 1'b1;
         end
      end else if (key_pulse_q[1]) begin
         music_d = nextSong(music_q);
      end else if (key_pulse_q[2]) begin
         music_d = prevSong(music_q);
      end else if (key_pulse_q[0] && (music_q == 2'd0)) begin
         music_d = 2'd1;
         play_d  = 1'b1;
      end

      if (key_pulse_q[0] && (music_q != 2'd0)) begin
         play_d = ~play_q;
      end

      if (key_pulse_q[3] && !key_pulse_q[4] && (volume_q < 3'd5)) begin
         volume_d = volume_q + 3'd1;
      end else if (key_pulse_q[4] && !key_pulse_q[3] && (volume_q > 3'd1)) begin
         volume_d = volume_q - 3'd1;
      end

      if (key_pulse_q[5]) begin
         speed_d = (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
      end

      if (key_pulse_q[6]) begin
         order_d = ~order_q;
      end

      if (music_d != music_q) begin
         restart_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q        <= '1;
         sync2_q        <= '1;
         stable_q       <= '1;
         stable_dly_q   <= '1;
         key_pulse_q    <= '0;
         for (int i = 0; i < 7; i++) begin
            cnt_q[i] <= '0;
         end
         order_q        <= 1'b0;
         music_q        <= 2'd0;
         volume_q       <= 3'd1;
         speed_q        <= 2'd0;
         play_q         <= 1'b0;
         restart_pend_q <= 1'b0;
         restart_q      <= 1'b0;
      end else begin
         sync1_q        <= key_n;
         sync2_q        <= sync1_q;
         stable_q       <= stable_d;
         stable_dly_q   <= stable_q;
         key_pulse_q    <= key_pulse_d;
         for (int i = 0; i < 7; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         order_q        <= order_d;
         music_q        <= music_d;
         volume_q       <= volume_d;
         speed_q        <= speed_d;
         play_q         <= play_d;
         restart_pend_q <= restart_pend_d;
         restart_q      <= restart_pend_q;
      end
   end

   assign order_reg  = order_q;
   assign music_reg  = music_q;
   assign volume_reg = volume_q;
   assign speed_reg  = speed_q;
   assign play_reg   = play_q;
   assign key_pulse  = key_pulse_q;
   assign restart    = restart_q;

endmodule

// File: tb/tb_music_ctrl_regs.sv
// Scoreboard bench for music_ctrl_regs: stimulus queues the expected key events,
// restarts and register snapshots; a monitor pops and compares as the DUT presents them.
module tb_music_ctrl_regs;

   typedef enum int {KindKey = 0, KindRestart = 1, KindSnap = 2} kind_e;

   typedef struct {
      kind_e      kind;
      logic [8:0] data;
      string      name;
   } entry_t;

   logic       clk;
   logic       rst_n;
   logic [6:0] key_n;
   logic       song_end;
   logic       order_reg;
   logic [1:0] music_reg;
   logic [2:0] volume_reg;
   logic [1:0] speed_reg;
   logic       play_reg;
   logic [6:0] key_pulse;
   logic       restart;

   entry_t expQ[$];
   int     testsRun;
   int     testsFailed;
   logic   snapReq;

   music_ctrl_regs #(.DEBOUNCE_CYC(4), .CNT_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n),
      .song_end   (song_end),
      .order_reg  (order_reg),
      .music_reg  (music_reg),
      .volume_reg (volume_reg),
      .speed_reg  (speed_reg),
      .play_reg   (play_reg),
      .key_pulse  (key_pulse),
      .restart    (restart)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pops the oldest expectation and compares it with what the DUT just presented.
   task automatic checkOutput(input kind_e kind, input logic [8:0] actual);
      entry_t e;
      testsRun++;
      if (expQ.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL unexpected output: got kind %0d data %h, expected nothing", kind, actual);
      end else begin
         e = expQ.pop_front();
         if (e.kind != kind || e.data != actual) begin
            testsFailed++;
            $display("[TB] FAIL %s: got kind %0d data %h, expected kind %0d data %h",
                     e.name, kind, actual, e.kind, e.data);
         end
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (key_pulse != 7'd0) checkOutput(KindKey, {2'b00, key_pulse});
         if (restart)           checkOutput(KindRestart, 9'd0);
         if (snapReq)           checkOutput(KindSnap, {order_reg, music_reg, volume_reg, speed_reg, play_reg});
      end
   end

   task automatic pushExp(input kind_e kind, input logic [8:0] data, input string name);
      entry_t e;
      e.kind = kind;
      e.data = data;
      e.name = name;
      expQ.push_back(e);
   endtask

   task automatic expectRegs(input string name, input logic o, input logic [1:0] m,
                             input logic [2:0] v, input logic [1:0] s, input logic p);
      @(negedge clk);
      pushExp(KindSnap, {o, m, v, s, p}, name);
      snapReq = 1'b1;
      @(negedge clk);
      snapReq = 1'b0;
   endtask

   // Presses the keys in mask cleanly, holds, releases and lets the release settle.
   task automatic applyStimulus(input logic [6:0] mask, input bit expRestart, input string name);
      pushExp(KindKey, {2'b00, mask}, {name, " pulse"});
      if (expRestart) pushExp(KindRestart, 9'd0, {name, " restart"});
      @(negedge clk);
      key_n = ~mask;
      repeat (14) @(negedge clk);
      key_n = 7'h7f;
      repeat (10) @(negedge clk);
   endtask

   task automatic pulseSongEnd(input bit expRestart, input string name);
      if (expRestart) pushExp(KindRestart, 9'd0, {name, " restart"});
      @(negedge clk);
      song_end = 1'b1;
      @(negedge clk);
      song_end = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      snapReq     = 1'b0;
      rst_n       = 1'b0;
      key_n       = 7'h7f;
      song_end    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      repeat (50) @(negedge clk);
      expectRegs("reset idle", 1'b0, 2'd0, 3'd1, 2'd0, 1'b0);

      // Bounce play: 2 low, 1 high, then a long hold.
      pushExp(KindKey, 9'h001, "bounce play pulse");
      pushExp(KindRestart, 9'd0, "bounce play restart");
      @(negedge clk);
      key_n[0] = 1'b0;
      repeat (2) @(negedge clk);
      key_n[0] = 1'b1;
      @(negedge clk);
      key_n[0] = 1'b0;
      repeat (20) @(negedge clk);
      key_n[0] = 1'b1;
      repeat (10) @(negedge clk);
      expectRegs("play from idle", 1'b0, 2'd1, 3'd1, 2'd0, 1'b1);

      applyStimulus(7'h02, 1'b1, "next 1");
      expectRegs("next to 2", 1'b0, 2'd2, 3'd1, 2'd0, 1'b1);
      applyStimulus(7'h02, 1'b1, "next 2");
      expectRegs("next to 3", 1'b0, 2'd3, 3'd1, 2'd0, 1'b1);
      applyStimulus(7'h02, 1'b1, "next 3");
      expectRegs("next wraps to 1", 1'b0, 2'd1, 3'd1, 2'd0, 1'b1);
      applyStimulus(7'h04, 1'b1, "prev");
      expectRegs("prev 1 to 3", 1'b0, 2'd3, 3'd1, 2'd0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(7'h08, 1'b0, "vol up");
         expectRegs("vol up", 1'b0, 2'd3, (i < 4) ? 3'(i + 2) : 3'd5, 2'd0, 1'b1);
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(7'h10, 1'b0, "vol down");
         expectRegs("vol down", 1'b0, 2'd3, (i < 4) ? 3'(4 - i) : 3'd1, 2'd0, 1'b1);
      end
      applyStimulus(7'h08, 1'b0, "vol up again");
      expectRegs("vol up to 2", 1'b0, 2'd3, 3'd2, 2'd0, 1'b1);
      applyStimulus(7'h18, 1'b0, "vol up+down");
      expectRegs("vol up+down holds", 1'b0, 2'd3, 3'd2, 2'd0, 1'b1);

      pulseSongEnd(1'b1, "song_end in order");
      expectRegs("song_end 3 to 1", 1'b0, 2'd1, 3'd2, 2'd0, 1'b1);
      applyStimulus(7'h40, 1'b0, "order toggle");
      expectRegs("order single", 1'b1, 2'd1, 3'd2, 2'd0, 1'b1);
      pulseSongEnd(1'b1, "song_end single");
      expectRegs("song_end single keeps", 1'b1, 2'd1, 3'd2, 2'd0, 1'b1);
      applyStimulus(7'h01, 1'b0, "pause");
      expectRegs("paused", 1'b1, 2'd1, 3'd2, 2'd0, 1'b0);
      pulseSongEnd(1'b0, "song_end paused");
      expectRegs("song_end paused ignored", 1'b1, 2'd1, 3'd2, 2'd0, 1'b0);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(7'h20, 1'b0, "speed");
         expectRegs("speed cycle", 1'b1, 2'd1, 3'd2, (i == 2) ? 2'd0 : 2'(i + 1), 1'b0);
      end

      // Reset while the speed key counter is mid-count, keeping the key held through release.
      @(negedge clk);
      key_n[5] = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      expectRegs("reset mid-debounce", 1'b0, 2'd0, 3'd1, 2'd0, 1'b0);
      pushExp(KindKey, 9'h020, "held through reset pulse");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (14) @(negedge clk);
      key_n[5] = 1'b1;
      repeat (10) @(negedge clk);
      expectRegs("speed after reset", 1'b0, 2'd0, 3'd1, 2'd1, 1'b0);

      repeat (10) @(negedge clk);
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL pending expectations: got %0d left, expected 0 (next: %s)",
                  expQ.size(), expQ[0].name);
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
